// File: rtl/pwm_breathe_pkg.sv
// Shared encodings for the breathing PWM generator: ramp modes and per-channel ramp state.
package pwm_breathe_pkg;

    localparam logic [1:0] MODE_TRI  = 2'd0;
    localparam logic [1:0] MODE_SAW  = 2'd1;
    localparam logic [1:0] MODE_HOLD = 2'd2;

    typedef enum logic {
        ST_UP   = 1'b0,
        ST_DOWN = 1'b1
    } ramp_state_t;

endpackage

// File: rtl/pwm_ramp_channel.sv
// One ramp engine: steps its duty value up/down (triangle) or up-and-wrap (sawtooth) on each tick.
module pwm_ramp_channel
    import pwm_breathe_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_step,
    output logic [WIDTH-1:0] o_duty,
    output logic             o_dir,
    output logic             o_at_max
);

    localparam logic [WIDTH:0]   MAX_X    = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0] RST_DUTY = WIDTH'(RESET_VAL);

    ramp_state_t      r_state;
    ramp_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_duty;
    logic [WIDTH-1:0] w_duty_nxt;
    logic [WIDTH:0]   w_duty_x;
    logic [WIDTH:0]   w_step_x;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_up_lim;

    // One extra bit so the saturation checks never see a wrapped value.
    assign w_duty_x = {1'b0, r_duty};
    assign w_step_x = {1'b0, i_step};
    assign w_sum    = w_duty_x + w_step_x;
    assign w_up_lim = MAX_X - w_step_x;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_UP;
            r_duty  <= RST_DUTY;
        end else begin
            r_state <= w_state_nxt;
            r_duty  <= w_duty_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        if (i_tick) begin
            case (i_mode)
                MODE_TRI: begin
                    if (r_state == ST_UP) begin
                        if (w_duty_x < w_up_lim) begin
                            w_duty_nxt = w_sum[WIDTH-1:0];
                        end else begin
                            w_duty_nxt  = '1;
                            w_state_nxt = ST_DOWN;
                        end
                    end else begin
                        if (r_duty > i_step) begin
                            w_duty_nxt = r_duty - i_step;
                        end else begin
                            w_duty_nxt  = '0;
                            w_state_nxt = ST_UP;
                        end
                    end
                end
                MODE_SAW: begin
                    w_state_nxt = ST_UP;
                    if (r_duty == '1) begin
                        w_duty_nxt = '0;
                    end else if (w_sum[WIDTH]) begin
                        w_duty_nxt = '1;
                    end else begin
                        w_duty_nxt = w_sum[WIDTH-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_duty   = r_duty;
    assign o_dir    = (r_state == ST_DOWN);
    // Flags the tick that brings the duty up to MAX, not ticks that merely keep it there.
    assign o_at_max = (w_duty_nxt == '1) && (r_duty != '1);

endmodule

// File: rtl/pwm_breathe_gen.sv
// Multi-channel breathing PWM: shared prescaler and PWM counter, per-channel ramp, shadowed compare.
module pwm_breathe_gen
    import pwm_breathe_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int PRESCALE_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_en,
    input  logic [1:0]                i_mode,
    input  logic [WIDTH-1:0]          i_step,
    input  logic [PRESCALE_W-1:0]     i_prescale,
    output logic [CHANNELS*WIDTH-1:0] o_duty_out,
    output logic [CHANNELS-1:0]       o_dir_out,
    output logic [CHANNELS-1:0]       o_pwm_out,
    output logic                      o_peak_pulse
);

    localparam logic [CHANNELS-1:0] PEAK_SEL = CHANNELS'(1);

    logic [PRESCALE_W-1:0] r_pre_cnt;
    logic                  w_tick;
    logic [WIDTH-1:0]      r_pwm_cnt;
    logic                  w_period_end;
    logic [CHANNELS-1:0]   w_at_max;
    logic                  r_peak;

    assign w_tick       = i_en && (r_pre_cnt == i_prescale);
    assign w_period_end = (r_pwm_cnt == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre_cnt <= '0;
        end else if (!i_en || w_tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt <= '0;
            r_peak    <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            r_peak    <= |(w_at_max & PEAK_SEL);
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        localparam int unsigned RV = (g * (1 << WIDTH)) / CHANNELS;

        logic [WIDTH-1:0] r_shadow;
        logic             r_pwm;

        pwm_ramp_channel #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RV)
        ) u_ramp (
            .clk      (clk),
            .rst      (rst),
            .i_tick   (w_tick),
            .i_mode   (i_mode),
            .i_step   (i_step),
            .o_duty   (o_duty_out[g*WIDTH +: WIDTH]),
            .o_dir    (o_dir_out[g]),
            .o_at_max (w_at_max[g])
        );

        // Shadow only follows the live duty at the period boundary, keeping each period whole.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_shadow <= WIDTH'(RV);
                r_pwm    <= 1'b0;
            end else begin
                if (w_period_end) begin
                    r_shadow <= o_duty_out[g*WIDTH +: WIDTH];
                end
                r_pwm <= (r_pwm_cnt < r_shadow);
            end
        end

        assign o_pwm_out[g] = r_pwm;
    end

    assign o_peak_pulse = r_peak;

endmodule

// File: tb/tb_pwm_breathe_gen.sv
// Directed bench for pwm_breathe_gen: channel-0 ramp scoreboard plus direct reset/latency/PWM checks.
module tb_pwm_breathe_gen;

    localparam int WIDTH      = 8;
    localparam int CHANNELS   = 4;
    localparam int PRESCALE_W = 16;
    localparam int W          = 9;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      en = 1'b0;
    logic [1:0]                mode = 2'd2;
    logic [WIDTH-1:0]          step = '0;
    logic [PRESCALE_W-1:0]     prescale = '0;
    logic [CHANNELS*WIDTH-1:0] duty_out;
    logic [CHANNELS-1:0]       dir_out;
    logic [CHANNELS-1:0]       pwm_out;
    logic                      peak_pulse;

    pwm_breathe_gen #(
        .WIDTH      (WIDTH),
        .CHANNELS   (CHANNELS),
        .PRESCALE_W (PRESCALE_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_en         (en),
        .i_mode       (mode),
        .i_step       (step),
        .i_prescale   (prescale),
        .o_duty_out   (duty_out),
        .o_dir_out    (dir_out),
        .o_pwm_out    (pwm_out),
        .o_peak_pulse (peak_pulse)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Independent model of the free-running PWM counter (cycles since reset release).
    int cyc = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // ---------------- scoreboard ----------------
    int         n_tests = 0;
    int         n_fail = 0;
    logic [W-1:0] exp_q[$];
    logic       mon_en = 1'b0;
    int         peaks_seen = 0;
    logic [W-1:0] prev_obs;
    logic [W-1:0] obs_v;
    logic [W-1:0] exp_v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every change of channel 0 {dir, duty} is a DUT response popped from the queue.
    always @(negedge clk) begin
        obs_v = {dir_out[0], duty_out[WIDTH-1:0]};
        if (peak_pulse) peaks_seen++;
        if (mon_en && (obs_v !== prev_obs)) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL ch0_ramp: unexpected change to %0h, queue empty", obs_v);
            end else begin
                exp_v = exp_q.pop_front();
                check("ch0_ramp", 32'(obs_v), 32'(exp_v));
            end
        end
        prev_obs = obs_v;
    end

    // ---------------- driver tasks ----------------
    int   hi_cnt[CHANNELS];
    logic s_first;
    logic s_63;
    logic s_64;

    task automatic pulse_reset();
        @(negedge clk);
        mon_en = 1'b0;
        en     = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic push(input logic dir, input logic [WIDTH-1:0] duty);
        exp_q.push_back({dir, duty});
    endtask

    task automatic run_ticks(input int n);
        en = 1'b1;
        repeat (n) @(negedge clk);
        en = 1'b0;
    endtask

    task automatic align_period();
        int guard;
        guard = 0;
        @(negedge clk);
        while ((cyc % 256) != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("period_align", 32'(guard < 300), 32'd1);
    endtask

    // Samples one full PWM period starting right after a pwm_cnt==0 negedge.
    task automatic measure_period(input bit mid_tick);
        for (int c = 0; c < CHANNELS; c++) hi_cnt[c] = 0;
        for (int j = 0; j < 256; j++) begin
            @(negedge clk);
            for (int c = 0; c < CHANNELS; c++) hi_cnt[c] += int'(pwm_out[c]);
            if (j == 0)  s_first = pwm_out[0];
            if (j == 63) s_63 = pwm_out[0];
            if (j == 64) s_64 = pwm_out[0];
            if (mid_tick && j == 128) begin
                mode = 2'd0;
                step = 8'd64;
                en   = 1'b1;
            end
            if (mid_tick && j == 129) begin
                en   = 1'b0;
                mode = 2'd2;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_duty", duty_out, 32'hC080_4000);
        check("rst_dir", 32'(dir_out), 32'h0);
        check("rst_pwm", 32'(pwm_out), 32'h0);
        check("rst_peak", 32'(peak_pulse), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Triangle, step 100, tick every cycle
        push(0, 100); push(0, 200); push(1, 255); push(1, 155);
        push(1, 55);  push(0, 0);   push(0, 100);
        peaks_seen = 0;
        mon_en   = 1'b1;
        mode     = 2'd0;
        step     = 8'd100;
        prescale = '0;
        run_ticks(7);
        check("tri_ch1", 32'(duty_out[15:8]), 32'd200);
        check("tri_peaks", 32'(peaks_seen), 32'd1);

        // Sawtooth, then asynchronous reset while running
        pulse_reset();
        push(0, 100); push(0, 200); push(0, 255); push(0, 0); push(0, 100);
        peaks_seen = 0;
        mon_en = 1'b1;
        mode   = 2'd1;
        en     = 1'b1;
        repeat (5) @(negedge clk);
        #2 mon_en = 1'b0;
        check("saw_peaks", 32'(peaks_seen), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("midrst_duty", duty_out, 32'hC080_4000);
        check("midrst_dir", 32'(dir_out), 32'h0);
        check("midrst_pwm", 32'(pwm_out), 32'h0);
        check("midrst_peak", 32'(peak_pulse), 32'h0);
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Prescaler and enable gating
        push(0, 1); push(0, 2); push(0, 3);
        mon_en   = 1'b1;
        mode     = 2'd0;
        step     = 8'd1;
        prescale = 16'd3;
        en       = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_before_tick", 32'(duty_out[7:0]), 32'd0);
        @(negedge clk);
        check("pre_tick1", 32'(duty_out[7:0]), 32'd1);
        repeat (4) @(negedge clk);
        check("pre_tick2", 32'(duty_out[7:0]), 32'd2);
        @(negedge clk);
        en = 1'b0;
        repeat (10) @(negedge clk);
        check("en_low_frozen", 32'(duty_out[7:0]), 32'd2);
        en = 1'b1;
        repeat (3) @(negedge clk);
        check("reen_before_tick", 32'(duty_out[7:0]), 32'd2);
        @(negedge clk);
        check("reen_tick", 32'(duty_out[7:0]), 32'd3);
        en = 1'b0;

        // PWM duty and glitch-free shadow update
        pulse_reset();
        push(0, 64);
        peaks_seen = 0;
        mon_en   = 1'b1;
        mode     = 2'd0;
        step     = 8'd64;
        prescale = '0;
        run_ticks(1);
        mode = 2'd2;
        align_period();
        push(0, 128);
        measure_period(1'b1);
        check("pwm_ch0_hi", 32'(hi_cnt[0]), 32'd64);
        check("pwm_ch1_hi", 32'(hi_cnt[1]), 32'd128);
        check("pwm_ch2_hi", 32'(hi_cnt[2]), 32'd192);
        check("pwm_ch3_max_hi", 32'(hi_cnt[3]), 32'd255);
        check("pwm_first_hi", 32'(s_first), 32'd1);
        check("pwm_last_hi", 32'(s_63), 32'd1);
        check("pwm_first_lo", 32'(s_64), 32'd0);
        measure_period(1'b0);
        check("upd_ch0_hi", 32'(hi_cnt[0]), 32'd128);
        check("upd_ch1_hi", 32'(hi_cnt[1]), 32'd192);
        check("upd_ch2_hi", 32'(hi_cnt[2]), 32'd255);
        check("upd_ch3_hi", 32'(hi_cnt[3]), 32'd191);

        // Sawtooth to MAX, step=0 triangle flip, hold, resume
        push(0, 192); push(0, 255);
        mode = 2'd1;
        step = 8'd64;
        run_ticks(2);
        push(1, 255);
        mode = 2'd0;
        step = 8'd0;
        run_ticks(1);
        check("step0_dir", 32'(dir_out), 32'h1);
        check("step0_duty", duty_out, 32'h0040_00FF);
        mode = 2'd2;
        step = 8'd100;
        run_ticks(10);
        mode = 2'd3;
        run_ticks(10);
        check("hold_duty", duty_out, 32'h0040_00FF);
        check("hold_dir", 32'(dir_out), 32'h1);
        push(1, 155);
        mode = 2'd0;
        run_ticks(1);
        check("resume_duty", duty_out, 32'h64A4_649B);
        check("late_peaks", 32'(peaks_seen), 32'd1);
        repeat (2) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
